// File: rtl/relogio_min_hora.sv
// relogio_min_hora: minutes/hours stage of the clock.
// Counts minutes (0..59) and hours (0..HORAS_MOD-1) from the seconds-stage
// carry. Emits a one-cycle day carry on the wrap to 00:00. Two debounced
// buttons (mode, up) drive a RUN -> SET_H -> SET_M -> RUN time-set machine.
// All outputs come straight from registers.
module relogio_min_hora #(
  parameter int HORAS_MOD = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       carry_i,
  input  logic       mode_i,
  input  logic       up_i,
  output logic [5:0] minutos_o,
  output logic [4:0] horas_o,
  output logic       dia_o,
  output logic [1:0] estado_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10,
    ST_BAD   = 2'b11
  } estado_t;

  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HORA_MAX = 5'(HORAS_MOD - 1);

  // Terminal value is compared before incrementing, so the field never
  // relies on natural overflow. ">=" also pulls any out-of-range value back.
  function automatic logic [5:0] inc_min(input logic [5:0] v);
    if (v >= MIN_MAX) begin
      inc_min = 6'd0;
    end else begin
      inc_min = v + 6'd1;
    end
  endfunction

  function automatic logic [4:0] inc_hora(input logic [4:0] v);
    if (v >= HORA_MAX) begin
      inc_hora = 5'd0;
    end else begin
      inc_hora = v + 5'd1;
    end
  endfunction

  estado_t    estado_r;
  estado_t    estado_nxt_s;
  logic [5:0] minutos_r;
  logic [5:0] minutos_nxt_s;
  logic [4:0] horas_r;
  logic [4:0] horas_nxt_s;
  logic       dia_r;
  logic       dia_nxt_s;
  logic       mode_prev_r;
  logic       up_prev_r;
  logic       mode_rise_s;
  logic       up_rise_s;

  // Rising-edge detection of the (already synchronous) buttons.
  always_comb begin
    mode_rise_s = mode_i & ~mode_prev_r;
    up_rise_s   = up_i & ~up_prev_r;
  end

  // Next-state logic: the state only advances on a mode rise; the
  // unreachable encoding falls back to RUN.
  always_comb begin
    estado_nxt_s = estado_r;
    case (estado_r)
      ST_RUN: begin
        if (mode_rise_s) begin
          estado_nxt_s = ST_SET_H;
        end else begin
          estado_nxt_s = ST_RUN;
        end
      end
      ST_SET_H: begin
        if (mode_rise_s) begin
          estado_nxt_s = ST_SET_M;
        end else begin
          estado_nxt_s = ST_SET_H;
        end
      end
      ST_SET_M: begin
        if (mode_rise_s) begin
          estado_nxt_s = ST_RUN;
        end else begin
          estado_nxt_s = ST_SET_M;
        end
      end
      default: begin
        estado_nxt_s = ST_RUN;
      end
    endcase
  end

  // Counter next values, decided by the state held at the start of the
  // cycle. Carries are only honoured in RUN; set modes ignore (and lose) them.
  always_comb begin
    minutos_nxt_s = minutos_r;
    horas_nxt_s   = horas_r;
    dia_nxt_s     = 1'b0;
    case (estado_r)
      ST_RUN: begin
        if (carry_i) begin
          minutos_nxt_s = inc_min(minutos_r);
          if (minutos_r >= MIN_MAX) begin
            horas_nxt_s = inc_hora(horas_r);
            if (horas_r >= HORA_MAX) begin
              dia_nxt_s = 1'b1;
            end else begin
              dia_nxt_s = 1'b0;
            end
          end else begin
            horas_nxt_s = horas_r;
          end
        end else begin
          minutos_nxt_s = minutos_r;
        end
      end
      ST_SET_H: begin
        if (up_rise_s) begin
          horas_nxt_s = inc_hora(horas_r);
        end else begin
          horas_nxt_s = horas_r;
        end
      end
      ST_SET_M: begin
        if (up_rise_s) begin
          minutos_nxt_s = inc_min(minutos_r);
        end else begin
          minutos_nxt_s = minutos_r;
        end
      end
      default: begin
        minutos_nxt_s = minutos_r;
        horas_nxt_s   = horas_r;
      end
    endcase
  end

  // State, counters, day pulse and button history; reset loads the live
  // button levels so a button held through reset produces no edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_r    <= ST_RUN;
      minutos_r   <= 6'd0;
      horas_r     <= 5'd0;
      dia_r       <= 1'b0;
      mode_prev_r <= mode_i;
      up_prev_r   <= up_i;
    end else begin
      estado_r    <= estado_nxt_s;
      minutos_r   <= minutos_nxt_s;
      horas_r     <= horas_nxt_s;
      dia_r       <= dia_nxt_s;
      mode_prev_r <= mode_i;
      up_prev_r   <= up_i;
    end
  end

  assign minutos_o = minutos_r;
  assign horas_o   = horas_r;
  assign dia_o     = dia_r;
  assign estado_o  = estado_r;

endmodule

// File: tb/tb_relogio_min_hora.sv
// Testbench for relogio_min_hora: a 24-hour and a 12-hour instance share
// the same stimulus. A time-of-day model (minutes since midnight) predicts
// both every cycle; directed literal checks pin the model to known values.
module tb_relogio_min_hora;

  logic       clk;
  logic       rst;
  logic       carry;
  logic       mode;
  logic       up;
  logic [5:0] min24, min12;
  logic [4:0] hr24, hr12;
  logic       dia24, dia12;
  logic [1:0] st24, st12;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // model state: index 0 -> 24 h instance, 1 -> 12 h instance
  int hmod [2] = '{24, 12};
  int t_m  [2];
  int dia_m[2];
  int st_m;
  int mp_m, upp_m;

  relogio_min_hora #(.HORAS_MOD(24)) u_dut24 (
    .clk_i(clk), .rst_i(rst), .carry_i(carry), .mode_i(mode), .up_i(up),
    .minutos_o(min24), .horas_o(hr24), .dia_o(dia24), .estado_o(st24));

  relogio_min_hora #(.HORAS_MOD(12)) u_dut12 (
    .clk_i(clk), .rst_i(rst), .carry_i(carry), .mode_i(mode), .up_i(up),
    .minutos_o(min12), .horas_o(hr12), .dia_o(dia12), .estado_o(st12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: time as minutes since midnight, state as 0/1/2.
  always @(posedge clk) begin
    int mr, ur;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        t_m[k] = 0;
        dia_m[k] = 0;
      end
      st_m = 0;
    end else begin
      mr = (mode && !mp_m) ? 1 : 0;
      ur = (up && !upp_m) ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
        dia_m[k] = 0;
        if (st_m == 0 && carry) begin
          t_m[k] = (t_m[k] + 1) % (hmod[k] * 60);
          dia_m[k] = (t_m[k] == 0) ? 1 : 0;
        end else if (st_m == 1 && ur == 1) begin
          t_m[k] = (((t_m[k] / 60) + 1) % hmod[k]) * 60 + (t_m[k] % 60);
        end else if (st_m == 2 && ur == 1) begin
          t_m[k] = (t_m[k] / 60) * 60 + ((t_m[k] % 60) + 1) % 60;
        end
      end
      if (mr == 1) st_m = (st_m + 1) % 3;
    end
    mp_m  = mode ? 1 : 0;
    upp_m = up ? 1 : 0;
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m24_min", int'(min24), t_m[0] % 60);
      cmp("m24_hr",  int'(hr24),  t_m[0] / 60);
      cmp("m24_dia", int'(dia24), dia_m[0]);
      cmp("m24_st",  int'(st24),  st_m);
      cmp("m12_min", int'(min12), t_m[1] % 60);
      cmp("m12_hr",  int'(hr12),  t_m[1] / 60);
      cmp("m12_dia", int'(dia12), dia_m[1]);
      cmp("m12_st",  int'(st12),  st_m);
    end
  end

  // Apply inputs at a negedge, return at the next negedge (results visible).
  task automatic cyc(input logic c, input logic m, input logic u);
    carry = c;
    mode  = m;
    up    = u;
    @(negedge clk);
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_mode();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; carry = 1'b0; mode = 1'b1; up = 1'b1;
    // reset with both buttons held, then keep holding
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk_en = 1'b1;
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cmp("rst_min", int'(min24), 0);
    cmp("rst_hr",  int'(hr24), 0);
    cmp("rst_st",  int'(st24), 0);
    cyc(1'b0, 1'b0, 1'b0);

    // minute-to-hour carry with back-to-back pulses
    repeat (59) cyc(1'b1, 1'b0, 1'b0);
    cmp("c59_min", int'(min24), 59);
    cmp("c59_hr",  int'(hr24), 0);
    cyc(1'b1, 1'b0, 1'b0);
    cmp("c60_min", int'(min24), 0);
    cmp("c60_hr",  int'(hr24), 1);
    cyc(1'b0, 1'b0, 1'b0);

    // set sequence from 00:00
    do_reset();
    press_mode();
    cmp("set_st1", int'(st24), 1);
    press_up(3);
    cmp("set_hr3", int'(hr24), 3);
    press_mode();
    cmp("set_st2", int'(st24), 2);
    press_up(61);
    cmp("set_min1", int'(min24), 1);
    cmp("set_hr_keep", int'(hr24), 3);
    press_mode();
    cmp("set_st0", int'(st24), 0);

    // frozen time in SET_H, held button, mode+up together
    press_mode();
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    cmp("frz_min", int'(min24), 1);
    cmp("frz_hr",  int'(hr24), 3);
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cmp("held_hr", int'(hr24), 4);
    cyc(1'b0, 1'b1, 1'b1);
    cmp("mu_hr", int'(hr24), 5);
    cmp("mu_st", int'(st24), 2);
    cyc(1'b0, 1'b0, 1'b0);

    // day wrap: preset 23:59 (11:59 on the 12 h instance)
    do_reset();
    press_mode();
    press_up(23);
    press_mode();
    press_up(59);
    press_mode();
    cmp("pre_hr24", int'(hr24), 23);
    cmp("pre_hr12", int'(hr12), 11);
    cmp("pre_min",  int'(min24), 59);
    cyc(1'b1, 1'b0, 1'b0);
    cmp("wrap_hr24",  int'(hr24), 0);
    cmp("wrap_min24", int'(min24), 0);
    cmp("wrap_dia24", int'(dia24), 1);
    cmp("wrap_hr12",  int'(hr12), 0);
    cmp("wrap_dia12", int'(dia12), 1);
    cyc(1'b0, 1'b0, 1'b0);
    cmp("wrap_dia_end", int'(dia24), 0);

    // mode rise + carry in RUN
    cyc(1'b1, 1'b1, 1'b0);
    cmp("mc_min", int'(min24), 1);
    cmp("mc_st",  int'(st24), 1);
    cyc(1'b0, 1'b0, 1'b0);

    // 12 up rises in SET_H from 0
    do_reset();
    press_mode();
    press_up(12);
    cmp("h12_hr12", int'(hr12), 0);
    cmp("h12_hr24", int'(hr24), 12);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      cyc(logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 11) == 0),
          logic'($urandom_range(0, 2) == 0));
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
